// File: rtl/tri_raster_collector_pkg.sv
// Shared constants for the triangle rasteriser collector: grid geometry,
// counter width and the collector state encoding.
package tri_raster_collector_pkg;

    // Default coordinate width; the grid is 2**TRI_COORD_W pixels square.
    localparam int TRI_COORD_W = 3;
    localparam int TRI_GRID    = 1 << TRI_COORD_W;

    // Pixel counter must be able to hold TRI_GRID*TRI_GRID.
    localparam int TRI_CNT_W   = 7;

    // Collector states.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DUMP    = 2'd2;

endpackage

// File: rtl/tri_raster_collector_if.sv
// Row readout channel from the collector to the host/checker.
// Handshake: a row word moves on every rising clk edge where rd_valid and
// rd_ready are both high. While rd_valid is high and rd_ready is low, the
// producer holds rd_row and rd_data stable. The producer never waits for
// rd_ready before raising rd_valid. The consumer may change rd_ready freely.
interface tri_raster_collector_if #(
    parameter int COORD_W = 3
) ();

    logic                      rd_valid;
    logic                      rd_ready;
    logic [COORD_W-1:0]        rd_row;
    logic [(1 << COORD_W)-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_row,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_row,
        input  rd_data,
        output rd_ready
    );

endinterface

// File: rtl/tri_raster_collector_bitmap.sv
// Square hit bitmap, one flop per pixel. A set port marks a pixel and also
// reports that pixel's previous value. A read port returns a whole row.
module tri_raster_collector_bitmap #(
    parameter int COORD_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      set_en,
    input  logic [COORD_W-1:0]        set_x,
    input  logic [COORD_W-1:0]        set_y,
    output logic                      hit,
    input  logic [COORD_W-1:0]        rd_y,
    output logic [(1 << COORD_W)-1:0] rd_row
);

    localparam int GRID = 1 << COORD_W;

    logic [GRID-1:0] bits [GRID];

    // Clear has priority over set so that a new frame always starts empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GRID; i++) begin
                bits[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < GRID; i++) begin
                bits[i] <= '0;
            end
        end else if (set_en) begin
            bits[set_y][set_x] <= 1'b1;
        end
    end

    assign hit    = bits[set_y][set_x];
    assign rd_row = bits[rd_y];

endmodule

// File: rtl/tri_raster_collector.sv
// Collects the rasteriser's inside-pixel strobes into a bitmap and a count
// of distinct pixels. When busy falls, it streams the bitmap out row by row.
module tri_raster_collector
    import tri_raster_collector_pkg::*;
#(
    parameter int COORD_W = TRI_COORD_W,
    parameter int CNT_W   = TRI_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   busy_i,
    input  logic                   po_i,
    input  logic [COORD_W-1:0]     xo_i,
    input  logic [COORD_W-1:0]     yo_i,
    tri_raster_collector_if.master rd,
    output logic [CNT_W-1:0]       pix_cnt,
    output logic                   done,
    output logic                   overrun,
    output logic [1:0]             dbg_state
);

    localparam int                 GRID     = 1 << COORD_W;
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(GRID * GRID);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(GRID - 1);

    logic [1:0]         state;
    logic               busy_d;
    logic               rise;
    logic               fall;
    logic               xfer;
    logic               rd_valid_q;
    logic [COORD_W-1:0] rd_row_q;
    logic               bm_clr;
    logic               bm_set;
    logic               bm_hit;
    logic [GRID-1:0]    bm_row;

    assign rise = busy_i & ~busy_d;
    assign fall = ~busy_i & busy_d;
    assign xfer = rd_valid_q & rd.rd_ready;

    // Registered copy of busy for the rise and fall edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_d <= 1'b0;
        end else begin
            busy_d <= busy_i;
        end
    end

    // Bitmap control: clear on a frame start (fresh or aborting a dump), record hits only while collecting.
    always_comb begin
        bm_clr = 1'b0;
        bm_set = 1'b0;
        case (state)
            ST_IDLE:    bm_clr = rise;
            ST_COLLECT: bm_set = po_i;
            ST_DUMP:    bm_clr = rise;
            default:    bm_clr = 1'b0;
        endcase
    end

    // Frame FSM, distinct-pixel counter and readout handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pix_cnt    <= '0;
            rd_valid_q <= 1'b0;
            rd_row_q   <= '0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        pix_cnt <= '0;
                        state   <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    // Only a pixel that was not already set adds to the count.
                    if (po_i && !bm_hit && (pix_cnt != CNT_MAX)) begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                    if (fall) begin
                        rd_row_q   <= '0;
                        rd_valid_q <= 1'b1;
                        state      <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    // A new frame aborts the dump even if a row is moving this cycle.
                    if (rise) begin
                        overrun    <= 1'b1;
                        rd_valid_q <= 1'b0;
                        rd_row_q   <= '0;
                        pix_cnt    <= '0;
                        state      <= ST_COLLECT;
                    end else if (xfer) begin
                        rd_row_q <= rd_row_q + 1'b1;
                        if (rd_row_q == LAST_ROW) begin
                            done       <= 1'b1;
                            rd_valid_q <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    tri_raster_collector_bitmap #(
        .COORD_W (COORD_W)
    ) u_bitmap (
        .clk    (clk),
        .reset  (reset),
        .clr    (bm_clr),
        .set_en (bm_set),
        .set_x  (xo_i),
        .set_y  (yo_i),
        .hit    (bm_hit),
        .rd_y   (rd_row_q),
        .rd_row (bm_row)
    );

    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_row   = rd_row_q;
    assign rd.rd_data  = bm_row;
    assign dbg_state   = state;

endmodule

// File: tb/tb_tri_raster_collector.sv
// Bench for tri_raster_collector: drives pixel frames and keeps a reference
// bitmap and distinct-pixel count. It checks the streamed rows, the counts
// and the done/overrun pulses.
module tb_tri_raster_collector;
  import tri_raster_collector_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic       busy_i;
  logic       po_i;
  logic [2:0] xo_i;
  logic [2:0] yo_i;
  logic [6:0] pix_cnt;
  logic       done;
  logic       overrun;
  logic [1:0] dbg_state;

  tri_raster_collector_if #(.COORD_W(3)) rd_if ();

  tri_raster_collector #(.COORD_W(3), .CNT_W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .busy_i    (busy_i),
    .po_i      (po_i),
    .xo_i      (xo_i),
    .yo_i      (yo_i),
    .rd        (rd_if),
    .pix_cnt   (pix_cnt),
    .done      (done),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [2:0] px_q[$];
  logic [2:0] py_q[$];
  logic [7:0] exp_q[$];
  int         exp_cnt;

  task automatic add_px(input int x, input int y);
    px_q.push_back(3'(x));
    py_q.push_back(3'(y));
  endtask

  task automatic clear_px();
    px_q.delete();
    py_q.delete();
  endtask

  // Bitmap is the set of strobed coordinates; count is its size.
  task automatic build_expect();
    bit         grid[8][8];
    logic [7:0] r;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        grid[y][x] = 1'b0;
    for (int i = 0; i < px_q.size(); i++)
      grid[py_q[i]][px_q[i]] = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    for (int y = 0; y < 8; y++) begin
      r = 8'h00;
      for (int x = 0; x < 8; x++) begin
        r[x] = grid[y][x];
        if (grid[y][x]) exp_cnt++;
      end
      exp_q.push_back(r);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_frame(input bit do_rise, input bit po_on_fall, input bit po_at_rise);
    if (do_rise) begin
      @(negedge clk);
      busy_i = 1'b1;
      po_i   = po_at_rise;
      xo_i   = 3'd0;
      yo_i   = 3'd0;
    end
    for (int i = 0; i < px_q.size(); i++) begin
      @(negedge clk);
      busy_i = !(po_on_fall && (i == px_q.size() - 1));
      po_i   = 1'b1;
      xo_i   = px_q[i];
      yo_i   = py_q[i];
    end
    if (!po_on_fall) begin
      @(negedge clk);
      busy_i = 1'b0;
      po_i   = 1'b0;
    end
  endtask

  // Consumes a full dump and checks every row against the model.
  task automatic do_dump(input int stall_row, input int stall_cyc, input bit rand_ready);
    int row = 0;
    int stalls = 0;
    int dones = 0;
    int budget = 400;
    bit first = 1'b1;
    bit fin = 1'b0;
    while (!fin && budget > 0) begin
      @(negedge clk);
      budget--;
      po_i = 1'b0;
      if (done) dones++;
      if (first) begin
        first = 1'b0;
        tests_run++;
        if (rd_if.rd_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL first_valid_latency: rd_valid=%0b expected 1", rd_if.rd_valid);
        end
      end
      if (row == 8) begin
        tests_run++;
        if (rd_if.rd_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL valid_drop: rd_valid=%0b expected 0", rd_if.rd_valid);
        end
        fin = 1'b1;
        rd_if.rd_ready = 1'b0;
      end else if (rd_if.rd_valid) begin
        tests_run++;
        if (rd_if.rd_row !== 3'(row)) begin
          tests_failed++;
          $display("FAIL dump_row_idx: rd_row=%0d expected %0d", rd_if.rd_row, row);
        end
        tests_run++;
        if (rd_if.rd_data !== exp_q[row]) begin
          tests_failed++;
          $display("FAIL dump_row_data: row %0d rd_data=%02h expected %02h", row, rd_if.rd_data, exp_q[row]);
        end
        if (row == stall_row && stalls < stall_cyc) begin
          rd_if.rd_ready = 1'b0;
          stalls++;
        end else if (rand_ready && $urandom_range(0, 2) == 0) begin
          rd_if.rd_ready = 1'b0;
        end else begin
          rd_if.rd_ready = 1'b1;
          row++;
        end
      end else begin
        rd_if.rd_ready = 1'b0;
      end
    end
    tests_run++;
    if (!fin) begin
      tests_failed++;
      $display("FAIL dump_timeout: rows received=%0d expected 8", row);
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++;
      $display("FAIL done_count: done pulses=%0d expected 1", dones);
    end
    tests_run++;
    if (pix_cnt !== 7'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL pix_cnt: pix_cnt=%0d expected %0d", pix_cnt, exp_cnt);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL state_after_dump: state=%0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    busy_i = 1'b0;
    po_i = 1'b0;
    xo_i = 3'd0;
    yo_i = 3'd0;
    rd_if.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rd_if.rd_valid, rd_if.rd_row, rd_if.rd_data} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_rd: valid=%0b row=%0d data=%02h expected 0/0/00", rd_if.rd_valid, rd_if.rd_row, rd_if.rd_data);
    end
    tests_run++;
    if ({pix_cnt, done, overrun} !== 9'h000) begin
      tests_failed++;
      $display("FAIL reset_outs: pix_cnt=%0d done=%0b overrun=%0b expected 0/0/0", pix_cnt, done, overrun);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d expected %0d", dbg_state, ST_IDLE);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_px();
    add_px(1, 1);
    add_px(2, 1);
    add_px(1, 2);
    build_expect();
    drive_frame(1'b1, 1'b0, 1'b0);
    do_dump(-1, 0, 1'b0);
  endtask

  task automatic test_duplicate();
    clear_px();
    add_px(3, 4);
    add_px(3, 4);
    build_expect();
    drive_frame(1'b1, 1'b0, 1'b0);
    do_dump(-1, 0, 1'b0);
  endtask

  task automatic test_stall();
    clear_px();
    add_px(0, 2);
    add_px(5, 2);
    add_px(6, 3);
    add_px(2, 7);
    build_expect();
    drive_frame(1'b1, 1'b0, 1'b0);
    do_dump(2, 5, 1'b0);
  endtask

  task automatic test_overrun();
    clear_px();
    add_px(4, 5);
    add_px(1, 0);
    add_px(7, 6);
    build_expect();
    drive_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_row !== 3'(i) || rd_if.rd_data !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL ovr_pre_rows: valid=%0b row=%0d data=%02h expected 1/%0d/%02h", rd_if.rd_valid, rd_if.rd_row, rd_if.rd_data, i, exp_q[i]);
      end
      rd_if.rd_ready = 1'b1;
      if (i == 5) busy_i = 1'b1;
    end
    @(negedge clk);
    rd_if.rd_ready = 1'b0;
    tests_run++;
    if (overrun !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_pulse: overrun=%0b done=%0b expected 1/0", overrun, done);
    end
    tests_run++;
    if (rd_if.rd_valid !== 1'b0 || pix_cnt !== 7'd0 || dbg_state !== ST_COLLECT) begin
      tests_failed++;
      $display("FAIL ovr_abort: valid=%0b pix_cnt=%0d state=%0d expected 0/0/%0d", rd_if.rd_valid, pix_cnt, dbg_state, ST_COLLECT);
    end
    clear_px();
    add_px(2, 2);
    add_px(3, 3);
    build_expect();
    drive_frame(1'b0, 1'b0, 1'b0);
    do_dump(-1, 0, 1'b0);
  endtask

  task automatic test_fall_and_idle();
    logic [6:0] cnt_before;
    cnt_before = pix_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      po_i = 1'b1;
      xo_i = 3'd0;
      yo_i = 3'd0;
    end
    @(negedge clk);
    po_i = 1'b0;
    tests_run++;
    if (pix_cnt !== cnt_before || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL idle_po_ignored: pix_cnt=%0d state=%0d expected %0d/%0d", pix_cnt, dbg_state, cnt_before, ST_IDLE);
    end
    clear_px();
    add_px(4, 1);
    add_px(7, 7);
    build_expect();
    drive_frame(1'b1, 1'b1, 1'b1);
    do_dump(-1, 0, 1'b0);
  endtask

  task automatic test_full_grid();
    clear_px();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        add_px(x, y);
    for (int i = 0; i < 10; i++)
      add_px($urandom_range(0, 7), $urandom_range(0, 7));
    build_expect();
    drive_frame(1'b1, 1'b0, 1'b0);
    do_dump(-1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      clear_px();
      for (int i = 0; i < $urandom_range(1, 30); i++)
        add_px($urandom_range(0, 7), $urandom_range(0, 7));
      build_expect();
      drive_frame(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      do_dump($urandom_range(0, 7), $urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic test_reset_mid_dump();
    int dones = 0;
    clear_px();
    add_px(0, 0);
    add_px(5, 1);
    add_px(2, 3);
    build_expect();
    drive_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_if.rd_ready = 1'b1;
    end
    @(negedge clk);
    rd_if.rd_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (rd_if.rd_valid !== 1'b0 || pix_cnt !== 7'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outs: valid=%0b pix_cnt=%0d done=%0b expected 0/0/0", rd_if.rd_valid, pix_cnt, done);
    end
    tests_run++;
    if (rd_if.rd_row !== 3'd0 || rd_if.rd_data !== 8'h00 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL rst_mid_state: row=%0d data=%02h state=%0d expected 0/00/%0d", rd_if.rd_row, rd_if.rd_data, dbg_state, ST_IDLE);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_done: done pulses=%0d expected 0", dones);
    end
    clear_px();
    add_px(6, 0);
    add_px(1, 5);
    build_expect();
    drive_frame(1'b1, 1'b0, 1'b0);
    do_dump(-1, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duplicate();
    test_stall();
    test_overrun();
    test_fall_and_idle();
    test_full_grid();
    test_random();
    test_reset_mid_dump();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
